csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- COUNTER_WIDTH, 64, width of cycle/instret/hpm counters (legal 33..64).
- HPM_COUNTERS, 2, number of hpmcounterN channels (legal 0..8), mapped from N=3 upward.
- MISA_VALUE, 32'h40000100, constant read value of misa.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- core_clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_address  in  12  CSR address.
- csr_wdata  in  32  operand for write/set/clear.
- csr_rdata  out  32  old value of addressed CSR, combinational.
- csr_illegal  out  1  access illegal, combinational.
- trap_valid  in  1  take trap this cycle.
- trap_cause  in  32  ucause value; bit31 = interrupt.
- trap_pc  in  32  faulting PC.
- trap_tval  in  32  utval value.
- uret_valid  in  1  execute uret this cycle.
- trap_target  out  32  next PC for trap (from utvec) or uret (uepc).
- epc_out  out  32  current uepc.
- irq_ext, irq_timer, irq_soft  in  1 each  interrupt lines.
- interrupt_request  out  1  enabled interrupt pending.
- instret_inc  in  1  one instruction retired.
- hpm_event  in  HPM_COUNTERS  per-channel increment strobes.
- time_counter  in  64  external real-time value.

Function
REQ-003 Map SHALL be: ustatus 0x000, uie 0x004, utvec 0x005, uscratch 0x040, uepc 0x041, ucause 0x042, utval 0x043, uip 0x044, misa 0x301, mcountinhibit 0x320, cycle 0xC00, time 0xC01, instret 0xC02, hpmcounterN 0xC00+N, high halves at 0xC80+offset.
REQ-004 csr_illegal SHALL assert when csr_op!=00 and address is unmapped (including hpm N>=3+HPM_COUNTERS), or when op is write, or set/clear with csr_wdata!=0, to addresses 0xCxx; illegal access updates no state and csr_rdata SHALL read 0.
REQ-005 Legal access SHALL update at next edge: write new=wdata, set new=old|wdata, clear new=old&~wdata; misa writes ignored without illegal.
REQ-006 Implemented bits: ustatus[0] UIE, [4] UPIE, rest read 0; uie/uip bits 0 (soft), 4 (timer), 8 (ext); uepc[1:0] forced 0 on every write path; mcountinhibit bit0 cycle, bit2 instret, bit(3+i) hpm i, others 0.
REQ-007 uip SHALL be registered: each edge uip[8]<=irq_ext, uip[4]<=irq_timer, uip[0]<=irq_soft; software writes to uip ignored.
REQ-008 interrupt_request SHALL be combinational ustatus.UIE & |(uie & uip).
REQ-009 Counters SHALL be COUNTER_WIDTH bits: cycle +1 every edge, instret +1 when instret_inc, hpm i +1 when hpm_event[i], each only if its inhibit bit is 0; all-ones wraps to 0.
REQ-010 Low half reads counter[31:0]; high half reads counter[COUNTER_WIDTH-1:32] zero-extended; time/timeh read time_counter directly.
REQ-011 trap_valid SHALL at next edge: uepc<=trap_pc&~3, ucause<=trap_cause, utval<=trap_tval, UPIE<=UIE, UIE<=0.
REQ-012 trap_target with trap_valid SHALL be {utvec[31:2],2'b00}, plus 4*trap_cause[30:0] when utvec[1:0]==01 and trap_cause[31]=1; with uret_valid it SHALL be uepc; otherwise 0.
REQ-013 uret_valid SHALL at next edge set UIE<=UPIE, UPIE<=1.
REQ-014 Priority same cycle: trap_valid > uret_valid > CSR op; lower-priority update dropped in full (csr_illegal still reported).
REQ-015 Counter increment and counter-related CSR write in same cycle: mcountinhibit write takes effect from next cycle; the current cycle's increment uses old inhibit.

Reset
REQ-016 reset high at an edge SHALL clear all registers to 0 (counters, ustatus, uie, uip, utvec, uscratch, uepc, ucause, utval, mcountinhibit), overriding any trap, uret or CSR op that cycle; misa always reads MISA_VALUE.
REQ-017 During reset combinational outputs SHALL reflect the held state; after release cycle reads 0 on the first cycle, 1 on the next.

Verification
REQ-018 Reset, then read 0xC00 over 3 cycles -> 0, 1, 2; read 0x301 -> 32'h40000100.
REQ-019 Write utvec=0x1001, UIE=1, uie=0x100, raise irq_ext -> interrupt_request=1 one cycle later; trap cause 0x8000000B, pc 0x2003 -> trap_target 0x102C, uepc 0x2000, UIE=0, UPIE=1.
REQ-020 uret after REQ-019 -> trap_target 0x2000, next cycle UIE=1, UPIE=1.
REQ-021 Set mcountinhibit=0x5, pulse instret_inc 4 cycles -> instret and cycle frozen; clear inhibit -> both resume; preload near wrap with COUNTER_WIDTH=33 -> 0x1_FFFFFFFF rolls to 0.
REQ-022 Write 0xC00, read 0x7FF, set 0xC02 with wdata 0 -> illegal, illegal, legal with no change.
REQ-023 trap_valid and csr write to uscratch same cycle -> uscratch unchanged, trap fields updated; reset asserted with trap -> all zero.

Source files
------------

// File: rtl/csr_unit.sv
// User-mode CSR file: trap/uret state, interrupt pending logic and performance counters.
// Reads and illegal flag are combinational; all state updates on the next rising core_clock edge.
module csr_unit #(
    parameter int          COUNTER_WIDTH = 64,
    parameter int          HPM_COUNTERS  = 2,
    parameter logic [31:0] MISA_VALUE    = 32'h40000100
) (
    input  logic                                          core_clock,
    input  logic                                          reset,
    input  logic [1:0]                                    csr_op,
    input  logic [11:0]                                   csr_address,
    input  logic [31:0]                                   csr_wdata,
    output logic [31:0]                                   csr_rdata,
    output logic                                          csr_illegal,
    input  logic                                          trap_valid,
    input  logic [31:0]                                   trap_cause,
    input  logic [31:0]                                   trap_pc,
    input  logic [31:0]                                   trap_tval,
    input  logic                                          uret_valid,
    output logic [31:0]                                   trap_target,
    output logic [31:0]                                   epc_out,
    input  logic                                          irq_ext,
    input  logic                                          irq_timer,
    input  logic                                          irq_soft,
    output logic                                          interrupt_request,
    input  logic                                          instret_inc,
    input  logic [(HPM_COUNTERS > 0 ? HPM_COUNTERS : 1)-1:0] hpm_event,
    input  logic [63:0]                                   time_counter
);
    localparam int          HPM_N        = (HPM_COUNTERS > 0) ? HPM_COUNTERS : 1;
    localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'h1 << HPM_COUNTERS) - 32'h1) << 3);
    localparam logic [31:0] UIE_MASK     = 32'h111;

    logic                     r_uie_bit;
    logic                     r_upie;
    logic [31:0]              r_uie;
    logic [31:0]              r_utvec;
    logic [31:0]              r_uscratch;
    logic [31:0]              r_uepc;
    logic [31:0]              r_ucause;
    logic [31:0]              r_utval;
    logic [31:0]              r_uip;
    logic [31:0]              r_mcountinhibit;
    logic [COUNTER_WIDTH-1:0] r_cycle;
    logic [COUNTER_WIDTH-1:0] r_instret;
    logic [COUNTER_WIDTH-1:0] r_hpm [HPM_N];

    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_mapped;
    logic        w_csr_we;

    function automatic logic [31:0] hi32(input logic [COUNTER_WIDTH-1:0] c);
        logic [63:0] t;
        t = 64'(c);
        return t[63:32];
    endfunction

    always_comb begin
        w_old    = '0;
        w_mapped = 1'b1;
        case (csr_address)
            12'h000: w_old = {27'b0, r_upie, 3'b0, r_uie_bit};
            12'h004: w_old = r_uie;
            12'h005: w_old = r_utvec;
            12'h040: w_old = r_uscratch;
            12'h041: w_old = r_uepc;
            12'h042: w_old = r_ucause;
            12'h043: w_old = r_utval;
            12'h044: w_old = r_uip;
            12'h301: w_old = MISA_VALUE;
            12'h320: w_old = r_mcountinhibit;
            12'hC00: w_old = r_cycle[31:0];
            12'hC01: w_old = time_counter[31:0];
            12'hC02: w_old = r_instret[31:0];
            12'hC80: w_old = hi32(r_cycle);
            12'hC81: w_old = time_counter[63:32];
            12'hC82: w_old = hi32(r_instret);
            default: begin
                w_mapped = 1'b0;
                for (int i = 0; i < HPM_COUNTERS; i++) begin
                    if (csr_address == 12'(12'hC03 + i)) begin
                        w_mapped = 1'b1;
                        w_old    = r_hpm[i][31:0];
                    end
                    if (csr_address == 12'(12'hC83 + i)) begin
                        w_mapped = 1'b1;
                        w_old    = hi32(r_hpm[i]);
                    end
                end
            end
        endcase
    end

    // Counter space is read-only; a set/clear with zero operand is a pure read.
    assign csr_illegal = (csr_op != 2'b00) &&
                         (!w_mapped || ((csr_address[11:8] == 4'hC) &&
                                        ((csr_op == 2'b01) || (csr_wdata != 32'h0))));
    assign csr_rdata   = csr_illegal ? 32'h0 : w_old;

    always_comb begin
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_old | csr_wdata;
            default: w_new = w_old & ~csr_wdata;
        endcase
    end

    assign w_csr_we = (csr_op != 2'b00) && !csr_illegal && !trap_valid && !uret_valid;

    always_comb begin
        trap_target = 32'h0;
        if (trap_valid) begin
            trap_target = {r_utvec[31:2], 2'b00};
            if (r_utvec[1:0] == 2'b01 && trap_cause[31])
                trap_target = {r_utvec[31:2], 2'b00} + {trap_cause[29:0], 2'b00};
        end else if (uret_valid) begin
            trap_target = r_uepc;
        end
    end

    assign epc_out           = r_uepc;
    assign interrupt_request = r_uie_bit & |(r_uie & r_uip);

    always_ff @(posedge core_clock) begin
        if (reset) begin
            r_uie_bit       <= 1'b0;
            r_upie          <= 1'b0;
            r_uie           <= '0;
            r_utvec         <= '0;
            r_uscratch      <= '0;
            r_uepc          <= '0;
            r_ucause        <= '0;
            r_utval         <= '0;
            r_uip           <= '0;
            r_mcountinhibit <= '0;
            r_cycle         <= '0;
            r_instret       <= '0;
            for (int i = 0; i < HPM_N; i++) r_hpm[i] <= '0;
        end else begin
            r_uip <= {23'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft};

            // Increments use the inhibit value from before this edge's CSR write.
            if (!r_mcountinhibit[0]) r_cycle <= r_cycle + COUNTER_WIDTH'(1);
            if (!r_mcountinhibit[2] && instret_inc) r_instret <= r_instret + COUNTER_WIDTH'(1);
            for (int i = 0; i < HPM_COUNTERS; i++)
                if (!r_mcountinhibit[3+i] && hpm_event[i]) r_hpm[i] <= r_hpm[i] + COUNTER_WIDTH'(1);

            if (trap_valid) begin
                r_uepc    <= trap_pc & ~32'h3;
                r_ucause  <= trap_cause;
                r_utval   <= trap_tval;
                r_upie    <= r_uie_bit;
                r_uie_bit <= 1'b0;
            end else if (uret_valid) begin
                r_uie_bit <= r_upie;
                r_upie    <= 1'b1;
            end else if (w_csr_we) begin
                case (csr_address)
                    12'h000: begin
                        r_uie_bit <= w_new[0];
                        r_upie    <= w_new[4];
                    end
                    12'h004: r_uie           <= w_new & UIE_MASK;
                    12'h005: r_utvec         <= w_new;
                    12'h040: r_uscratch      <= w_new;
                    12'h041: r_uepc          <= w_new & ~32'h3;
                    12'h042: r_ucause        <= w_new;
                    12'h043: r_utval         <= w_new;
                    12'h320: r_mcountinhibit <= w_new & INHIBIT_MASK;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (33-bit counters, two hpm channels).
module tb_csr_unit;
    logic        core_clock = 1'b0;
    logic        reset;
    logic [1:0]  csr_op;
    logic [11:0] csr_address;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        uret_valid;
    logic [31:0] trap_target, epc_out;
    logic        irq_ext, irq_timer, irq_soft;
    logic        interrupt_request;
    logic        instret_inc;
    logic [1:0]  hpm_event;
    logic [63:0] time_counter;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_cycle = '0;
    logic        inh_cyc   = 1'b0;

    csr_unit #(.COUNTER_WIDTH(33), .HPM_COUNTERS(2), .MISA_VALUE(32'h40000100)) dut (
        .core_clock(core_clock), .reset(reset),
        .csr_op(csr_op), .csr_address(csr_address), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .uret_valid(uret_valid), .trap_target(trap_target),
        .epc_out(epc_out), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .interrupt_request(interrupt_request), .instret_inc(instret_inc),
        .hpm_event(hpm_event), .time_counter(time_counter)
    );

    always #5 core_clock = ~core_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (!reset && !inh_cyc) exp_cycle = exp_cycle + 33'd1;
        @(posedge core_clock);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_op      = op;
        csr_address = addr;
        csr_wdata   = wd;
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr(2'b00, addr, 32'h0);
    endtask

    initial begin
        reset = 1'b1; csr_op = 2'b00; csr_address = '0; csr_wdata = '0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; uret_valid = 1'b0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; instret_inc = 1'b0;
        hpm_event = 2'b00; time_counter = 64'h0000_0007_1234_5678;
        tick(); tick();
        reset = 1'b0;

        // Reset state and free-running cycle counter
        rd(12'hC00); check("cycle0", csr_rdata, 32'h0);
        check("epc_rst", epc_out, 32'h0);
        check("irq_rst", {31'b0, interrupt_request}, 32'h0);
        check("tgt_rst", trap_target, 32'h0);
        rd(12'h000); check("ustatus_rst", csr_rdata, 32'h0);
        tick(); rd(12'hC00); check("cycle1", csr_rdata, 32'h1);
        tick(); rd(12'hC00); check("cycle2", csr_rdata, 32'h2);
        rd(12'h301); check("misa", csr_rdata, 32'h40000100);
        rd(12'hC81); check("timeh", csr_rdata, 32'h7);
        csr(2'b01, 12'h301, 32'h0); check("misa_wr_ill", {31'b0, csr_illegal}, 32'h0);
        tick(); rd(12'h301); check("misa_keep", csr_rdata, 32'h40000100);

        // Interrupt enable path and vectored trap
        csr(2'b01, 12'h005, 32'h1001); tick();
        csr(2'b01, 12'h000, 32'h1);    tick();
        csr(2'b01, 12'h004, 32'h100);  tick();
        rd(12'h004); check("uie", csr_rdata, 32'h100);
        irq_ext = 1'b1; #1;
        check("irq_before", {31'b0, interrupt_request}, 32'h0);
        tick();
        check("irq_after", {31'b0, interrupt_request}, 32'h1);
        rd(12'h044); check("uip", csr_rdata, 32'h100);
        trap_valid = 1'b1; trap_cause = 32'h2; #1;
        check("tgt_exc", trap_target, 32'h1000);
        trap_cause = 32'h8000000B; trap_pc = 32'h2003; trap_tval = 32'h55; #1;
        check("tgt_vec", trap_target, 32'h102C);
        tick(); trap_valid = 1'b0; irq_ext = 1'b0; #1;
        check("uepc", epc_out, 32'h2000);
        rd(12'h000); check("ustatus_trap", csr_rdata, 32'h10);
        rd(12'h042); check("ucause", csr_rdata, 32'h8000000B);
        rd(12'h043); check("utval", csr_rdata, 32'h55);
        check("irq_masked", {31'b0, interrupt_request}, 32'h0);

        // uret
        uret_valid = 1'b1; #1;
        check("tgt_uret", trap_target, 32'h2000);
        tick(); uret_valid = 1'b0;
        rd(12'h000); check("ustatus_uret", csr_rdata, 32'h11);
        csr(2'b01, 12'h044, 32'h111); tick();
        rd(12'h044); check("uip_ro", csr_rdata, 32'h0);
        csr(2'b01, 12'h041, 32'h1237); tick();
        rd(12'h041); check("uepc_align", csr_rdata, 32'h1234);

        // Counter inhibit
        csr(2'b01, 12'h320, 32'hFFFFFFFF); tick(); inh_cyc = 1'b1;
        rd(12'h320); check("inh_mask", csr_rdata, 32'h1D);
        csr(2'b11, 12'h320, 32'hFFFFFFFF); tick(); inh_cyc = 1'b0;
        csr(2'b01, 12'h320, 32'h5); tick(); inh_cyc = 1'b1;
        rd(12'h320); check("inh5", csr_rdata, 32'h5);
        instret_inc = 1'b1; hpm_event = 2'b01;
        repeat (4) tick();
        rd(12'hC02); check("instret_frz", csr_rdata, 32'h0);
        rd(12'hC00); check("cycle_frz", csr_rdata, exp_cycle[31:0]);
        rd(12'hC03); check("hpm0", csr_rdata, 32'h4);
        rd(12'hC04); check("hpm1", csr_rdata, 32'h0);
        csr(2'b11, 12'h320, 32'h5); tick(); inh_cyc = 1'b0;
        rd(12'hC02); check("instret_old_inh", csr_rdata, 32'h0);
        tick(); instret_inc = 1'b0; hpm_event = 2'b00;
        rd(12'hC02); check("instret_run", csr_rdata, 32'h1);
        rd(12'hC00); check("cycle_run", csr_rdata, exp_cycle[31:0]);
        rd(12'hC03); check("hpm0_run", csr_rdata, 32'h6);

        // 33-bit wrap
        force dut.r_cycle = 33'h1_FFFF_FFFE;
        #1 release dut.r_cycle;
        exp_cycle = 33'h1_FFFF_FFFE;
        rd(12'hC80); check("cycleh_pre", csr_rdata, 32'h1);
        tick(); rd(12'hC00); check("cycle_ff", csr_rdata, 32'hFFFFFFFF);
        tick(); rd(12'hC00); check("cycle_wrap", csr_rdata, exp_cycle[31:0]);
        rd(12'hC80); check("cycleh_wrap", csr_rdata, {31'b0, exp_cycle[32]});

        // Illegal accesses
        csr(2'b01, 12'hC00, 32'h5); check("ill_wr_cnt", {31'b0, csr_illegal}, 32'h1);
        check("ill_rdata", csr_rdata, 32'h0);
        csr(2'b10, 12'h7FF, 32'h1); check("ill_unmap", {31'b0, csr_illegal}, 32'h1);
        csr(2'b10, 12'hC05, 32'h0); check("ill_hpm5", {31'b0, csr_illegal}, 32'h1);
        csr(2'b11, 12'hC02, 32'h1); check("ill_clr_cnt", {31'b0, csr_illegal}, 32'h1);
        csr(2'b00, 12'h7FF, 32'h1); check("noop_unmap", {31'b0, csr_illegal}, 32'h0);
        csr(2'b10, 12'hC02, 32'h0); check("set0_legal", {31'b0, csr_illegal}, 32'h0);
        check("set0_rdata", csr_rdata, 32'h1);
        tick(); rd(12'hC02); check("set0_nochg", csr_rdata, 32'h1);

        // Trap beats CSR write; reset beats trap
        csr(2'b01, 12'h040, 32'hAAAA); tick();
        trap_valid = 1'b1; trap_cause = 32'h5; trap_pc = 32'h3000; trap_tval = 32'h7;
        csr(2'b01, 12'h040, 32'h1234);
        check("trap_csr_legal", {31'b0, csr_illegal}, 32'h0);
        tick(); trap_valid = 1'b0;
        rd(12'h040); check("uscratch_keep", csr_rdata, 32'hAAAA);
        rd(12'h042); check("ucause_trap2", csr_rdata, 32'h5);
        check("uepc_trap2", epc_out, 32'h3000);
        reset = 1'b1; trap_valid = 1'b1; trap_pc = 32'h4444;
        tick(); reset = 1'b0; trap_valid = 1'b0; inh_cyc = 1'b0; exp_cycle = '0;
        check("rst_epc", epc_out, 32'h0);
        rd(12'h042); check("rst_ucause", csr_rdata, 32'h0);
        rd(12'h040); check("rst_uscratch", csr_rdata, 32'h0);
        rd(12'h005); check("rst_utvec", csr_rdata, 32'h0);
        rd(12'hC00); check("rst_cycle", csr_rdata, 32'h0);
        tick(); rd(12'hC00); check("rst_cycle1", csr_rdata, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
